// File: rtl/board_move_engine_pkg.sv
// Shared cell encodings, direction table, FSM states and colour defaults for the
// Reversi board/move engine.
package board_move_engine_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  localparam logic [2:0] DEF_COL_BLACK = 3'b000;
  localparam logic [2:0] DEF_COL_WHITE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PLACE,
    ST_FLIP,
    ST_DONE
  } state_e;

  // Directions 0..7: E, SE, S, SW, W, NW, N, NE with +y pointing down the board.
  function automatic logic signed [1:0] dir_dx(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: dir_dx = 2'b01;
      3'd3, 3'd4, 3'd5: dir_dx = 2'b11;
      default:          dir_dx = 2'b00;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: dir_dy = 2'b01;
      3'd5, 3'd6, 3'd7: dir_dy = 2'b11;
      default:          dir_dy = 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] first_dir(input logic [7:0] m);
    first_dir = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) first_dir = 3'(i);
    end
  endfunction

endpackage

// File: rtl/board_move_engine_if.sv
// Draw request channel from the move engine to the VGA draw path (valid/ready).
interface board_move_engine_if #(
  parameter int CW = 3
);
  logic          draw_valid;
  logic          draw_ready;
  logic [CW-1:0] draw_x;
  logic [CW-1:0] draw_y;
  logic [2:0]    draw_colour;

  modport master (output draw_valid, draw_x, draw_y, draw_colour, input draw_ready);
  modport slave  (input draw_valid, draw_x, draw_y, draw_colour, output draw_ready);
endinterface

// File: rtl/board_move_engine_ray_walker.sv
// Holds a board coordinate, exposes its neighbour along direction dir and whether
// that neighbour falls off the board; load re-seeds, adv moves onto the neighbour.
module ray_walker
  import board_move_engine_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int CW      = $clog2(BOARD_N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          adv,
  input  logic [CW-1:0] ld_x,
  input  logic [CW-1:0] ld_y,
  input  logic [2:0]    dir,
  output logic [CW-1:0] nxt_x,
  output logic [CW-1:0] nxt_y,
  output logic          nxt_off
);

  localparam logic [CW-1:0] MAXC = CW'(BOARD_N - 1);

  logic signed [CW:0] cur_x_q, cur_y_q;
  logic signed [CW:0] step_x, step_y, sum_x, sum_y;
  logic signed [1:0]  dx, dy;

  always_comb begin
    dx      = dir_dx(dir);
    dy      = dir_dy(dir);
    step_x  = {{(CW-1){dx[1]}}, dx};
    step_y  = {{(CW-1){dy[1]}}, dy};
    sum_x   = cur_x_q + step_x;
    sum_y   = cur_y_q + step_y;
    nxt_x   = sum_x[CW-1:0];
    nxt_y   = sum_y[CW-1:0];
    // The sign bit catches both stepping below 0 and wrapping past the top.
    nxt_off = sum_x[CW] || sum_y[CW] || (sum_x[CW-1:0] > MAXC) || (sum_y[CW-1:0] > MAXC);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else if (load) begin
      cur_x_q <= {1'b0, ld_x};
      cur_y_q <= {1'b0, ld_y};
    end else if (adv) begin
      cur_x_q <= sum_x;
      cur_y_q <= sum_y;
    end
  end

endmodule

// File: rtl/board_move_engine.sv
// Reversi board owner: validates a move over 8 rays, places and flips, and streams one
// draw request per changed cell; a stalled draw holds the FSM. Optional SCORE_EN adds piece counts.
module board_move_engine
  import board_move_engine_pkg::*;
#(
  parameter int         BOARD_N   = 8,
  parameter int         CW        = $clog2(BOARD_N),
  parameter logic [2:0] COL_BLACK = DEF_COL_BLACK,
  parameter logic [2:0] COL_WHITE = DEF_COL_WHITE,
  parameter int         SW        = $clog2(BOARD_N**2 + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [CW-1:0]        move_x,
  input  logic [CW-1:0]        move_y,
  input  logic                 player,
  input  logic                 check_only,
  output logic                 busy,
  output logic                 done,
  output logic                 valid_move,
  board_move_engine_if.master  draw,
  input  logic [CW-1:0]        rd_x,
  input  logic [CW-1:0]        rd_y,
  output logic [1:0]           rd_cell
`ifdef SCORE_EN
  ,
  output logic [SW-1:0]        score_black,
  output logic [SW-1:0]        score_white
`endif
);

  localparam int H = BOARD_N / 2;

  state_e        state_q;
  logic          busy_q, done_q, valid_q;
  logic          dv_q;
  logic [CW-1:0] dx_q, dy_q;
  logic [2:0]    dcol_q;
  logic [CW-1:0] mx_q, my_q;
  logic          player_q, chk_q;
  logic [2:0]    dir_q;
  logic [7:0]    mask_q;
  logic          seen_q;
  logic [1:0]    board_q [BOARD_N][BOARD_N];
`ifdef SCORE_EN
  logic [SW-1:0] score_black_q, score_white_q;
`endif

  logic          w_load, w_adv, w_off;
  logic [CW-1:0] w_ld_x, w_ld_y, w_x, w_y;
  logic [1:0]    own_cell, opp_cell, probe_cell;
  logic          probe_own, probe_opp, xfer;
  logic [7:0]    mask_d, flip_rem;
  logic [2:0]    own_col;

  ray_walker #(.BOARD_N(BOARD_N), .CW(CW)) u_walker (
    .clk    (clk),
    .resetn (resetn),
    .load   (w_load),
    .adv    (w_adv),
    .ld_x   (w_ld_x),
    .ld_y   (w_ld_y),
    .dir    (dir_q),
    .nxt_x  (w_x),
    .nxt_y  (w_y),
    .nxt_off(w_off)
  );

  always_comb begin
    own_cell   = player_q ? CELL_WHITE : CELL_BLACK;
    opp_cell   = player_q ? CELL_BLACK : CELL_WHITE;
    own_col    = player_q ? COL_WHITE : COL_BLACK;
    probe_cell = w_off ? CELL_EMPTY : board_q[w_y][w_x];
    probe_own  = !w_off && (probe_cell == own_cell);
    probe_opp  = !w_off && (probe_cell == opp_cell);
    xfer       = dv_q && draw.draw_ready;
    mask_d     = mask_q | ((seen_q && probe_own) ? (8'b1 << dir_q) : 8'b0);
    flip_rem   = mask_q & ~(8'b1 << dir_q);
  end

  // Walker is re-seeded at the target whenever a ray finishes, so each ray starts one step out.
  always_comb begin
    w_load = 1'b0;
    w_adv  = 1'b0;
    w_ld_x = mx_q;
    w_ld_y = my_q;
    case (state_q)
      ST_IDLE: begin
        w_load = start;
        w_ld_x = move_x;
        w_ld_y = move_y;
      end
      ST_SCAN: begin
        w_adv  = probe_opp;
        w_load = !probe_opp;
      end
      ST_PLACE: w_load = xfer;
      ST_FLIP: begin
        w_adv  = !dv_q && probe_opp;
        w_load = !dv_q && !probe_opp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      dv_q     <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      dcol_q   <= COL_BLACK;
      mx_q     <= '0;
      my_q     <= '0;
      player_q <= 1'b0;
      chk_q    <= 1'b0;
      dir_q    <= 3'd0;
      mask_q   <= 8'd0;
      seen_q   <= 1'b0;
      for (int y = 0; y < BOARD_N; y++) begin
        for (int x = 0; x < BOARD_N; x++) begin
          board_q[y][x] <= CELL_EMPTY;
        end
      end
      board_q[H-1][H-1] <= CELL_WHITE;
      board_q[H][H]     <= CELL_WHITE;
      board_q[H-1][H]   <= CELL_BLACK;
      board_q[H][H-1]   <= CELL_BLACK;
`ifdef SCORE_EN
      score_black_q <= SW'(2);
      score_white_q <= SW'(2);
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mx_q     <= move_x;
            my_q     <= move_y;
            player_q <= player;
            chk_q    <= check_only;
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
            dir_q    <= 3'd0;
            mask_q   <= 8'd0;
            seen_q   <= 1'b0;
            if (board_q[move_y][move_x] != CELL_EMPTY) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          mask_q <= mask_d;
          if (probe_opp) begin
            seen_q <= 1'b1;
          end else begin
            seen_q <= 1'b0;
            if (dir_q == 3'd7) begin
              if (mask_d == 8'd0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else if (chk_q) begin
                valid_q <= 1'b1;
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                valid_q <= 1'b1;
                state_q <= ST_PLACE;
                dv_q    <= 1'b1;
                dx_q    <= mx_q;
                dy_q    <= my_q;
                dcol_q  <= own_col;
              end
            end else begin
              dir_q <= dir_q + 3'd1;
            end
          end
        end
        ST_PLACE: begin
          if (xfer) begin
            dv_q    <= 1'b0;
            dir_q   <= first_dir(mask_q);
            state_q <= ST_FLIP;
          end
        end
        ST_FLIP: begin
          if (dv_q) begin
            if (draw.draw_ready) dv_q <= 1'b0;
          end else if (probe_opp) begin
            dv_q   <= 1'b1;
            dx_q   <= w_x;
            dy_q   <= w_y;
            dcol_q <= own_col;
          end else begin
            mask_q <= flip_rem;
            if (flip_rem == 8'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              dir_q <= first_dir(flip_rem);
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Every accepted draw is exactly one board write for the mover.
      if (xfer) begin
        board_q[dy_q][dx_q] <= own_cell;
`ifdef SCORE_EN
        if (player_q) begin
          score_white_q <= score_white_q + 1'b1;
          if (state_q == ST_FLIP) score_black_q <= score_black_q - 1'b1;
        end else begin
          score_black_q <= score_black_q + 1'b1;
          if (state_q == ST_FLIP) score_white_q <= score_white_q - 1'b1;
        end
`endif
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign valid_move       = valid_q;
  assign draw.draw_valid  = dv_q;
  assign draw.draw_x      = dx_q;
  assign draw.draw_y      = dy_q;
  assign draw.draw_colour = dcol_q;
  assign rd_cell          = board_q[rd_y][rd_x];
`ifdef SCORE_EN
  assign score_black      = score_black_q;
  assign score_white      = score_white_q;
`endif

endmodule
